change_dispenser_ctrl: RTL and testbench
========================================

// Module: change_dispenser_ctrl
// PURPOSE
//  Sequences the coin-return mechanism of the drink vending machine. It takes a change
//  amount from the vending FSM and pays it out one coin at a time, using greedy
//  denomination selection (10/5/1). Per-denomination stock is tracked, refills are
//  accepted at any time, and any shortfall or mechanism fault is reported.
// PARAMETERS
//  AMT_W       8    width of amount/remaining
//  STOCK_W     8    width of each stock counter; saturates at 2**STOCK_W-1
//  INIT_STOCK  20   value of every stock counter after reset
//  GAP_CYC     2    idle cycles between consecutive ejects (>=1)
//  TIMEOUT_CYC 64   max cycles eject may be held awaiting eject_done
// PORTS
//  clk          in   1        rising-edge clock
//  clear_n      in   1        asynchronous active-low reset
//  req_valid    in   1        change request present
//  req_ready    out  1        1 only in IDLE; request accepted when valid&&ready
//  req_amount   in   AMT_W    change to pay, dollars
//  eject        out  3        one-hot coin eject: [2]=10, [1]=5, [0]=1
//  eject_done   in   1        mechanism confirms current coin released
//  refill_valid in   1        add coins to stock this cycle
//  refill_sel   in   2        0:1-coin 1:5-coin 2:10-coin (3 ignored)
//  refill_count in   STOCK_W  coins added
//  stock_empty  out  3        per-denomination stock==0, same bit order as eject
//  busy         out  1        state != IDLE
//  done         out  1        1-cycle pulse at end of payout
//  short_amt    out  AMT_W    unpaid remainder; valid with done
//  fault        out  1        eject timed out; valid with done
// BEHAVIOUR
//  Reset: eject=0, done=0, fault=0, short_amt=0, busy=0, req_ready=1, state=IDLE,
//   stocks=INIT_STOCK. Asynchronous: eject drops immediately, even mid-payout.
//  FSM IDLE->SELECT->EJECT->GAP->SELECT ... ->DONE->IDLE.
//  IDLE: on accept, remaining<=req_amount, go to SELECT.
//  SELECT (1 cycle): pick the largest denomination d with value<=remaining and stock>0.
//   If remaining==0, or no d exists, go to DONE.
//  EJECT: eject=onehot(d) from the first EJECT cycle. Held until eject_done is sampled
//   high. On that edge: remaining-=value(d), stock[d]-=1, eject=0, go to GAP.
//   eject_done outside EJECT is ignored.
//  Timeout: TIMEOUT_CYC EJECT cycles without eject_done: eject=0, fault=1, stock and
//   remaining unchanged, go to DONE.
//  GAP: GAP_CYC cycles with eject=0, then SELECT.
//  DONE (1 cycle): done=1, short_amt=remaining, fault as set. Go to IDLE.
//   short_amt and fault hold until the next accept clears them.
//  Latency: zero-amount request gives done 2 cycles after the accept edge.
//  Refill: adds refill_count to stock[refill_sel] in any state, saturating.
//   Refill and decrement of the same counter in one cycle apply net +count-1, saturating.
//  Stock is never decremented below 0, because SELECT excludes empty denominations.
//  Arithmetic is unsigned. remaining never underflows: d is chosen with value<=remaining.
// TESTING
//  1 stocks 20/20/20, amount 27 -> eject 10,10,5,1,1; done, short_amt=0, fault=0;
//    stocks 10:18, 5:19, 1:18.
//  2 amount 0 -> no eject; done exactly 2 cycles after accept; short_amt=0.
//  3 stocks 10:0, 5:0, 1:2, amount 8 -> eject 1,1; done with short_amt=6;
//    stock_empty=3'b111.
//  4 amount 5, eject_done tied low -> eject[1] high for 64 cycles then low;
//    done with fault=1, short_amt=5; stock 5 unchanged.
//  5 refill_sel=2, refill_count=3 on the same edge that eject_done completes a 10 coin
//    (stock 4) -> stock 10 becomes 6. Refill to a counter at 250 with count 10 -> 255.
//  6 assert clear_n low mid-EJECT of a 27 payout -> eject=0 asynchronously; after
//    release: req_ready=1, busy=0, stocks=20.

Source files
------------

// File: rtl/change_dispenser_ctrl.sv
// Coin-return sequencer: pays a change amount one coin at a time
// using greedy 10/5/1 selection, tracks per-coin stock, flags faults.
module change_dispenser_ctrl #(
   parameter int AMT_W       = 8,
   parameter int STOCK_W     = 8,
   parameter int INIT_STOCK  = 20,
   parameter int GAP_CYC     = 2,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic               clk,
   input  logic               clear_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [AMT_W-1:0]   req_amount,
   output logic [2:0]         eject,
   input  logic               eject_done,
   input  logic               refill_valid,
   input  logic [1:0]         refill_sel,
   input  logic [STOCK_W-1:0] refill_count,
   output logic [2:0]         stock_empty,
   output logic               busy,
   output logic               done,
   output logic [AMT_W-1:0]   short_amt,
   output logic               fault
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SELECT,
      S_EJECT,
      S_GAP,
      S_DONE
   } state_t;

   localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
   localparam int GAP_W = $clog2(GAP_CYC + 1);

   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

   localparam logic [AMT_W-1:0] TEN  = AMT_W'(10);
   localparam logic [AMT_W-1:0] FIVE = AMT_W'(5);
   localparam logic [AMT_W-1:0] ONE  = AMT_W'(1);

   localparam logic [STOCK_W-1:0] STOCK_RST = STOCK_W'(INIT_STOCK);

   state_t state_q;
   state_t state_d;

   logic [AMT_W-1:0]   rem_q;
   logic [2:0]         sel_q;
   logic [2:0]         sel_d;
   logic [AMT_W-1:0]   coin_val;
   logic [TMR_W-1:0]   tmr_q;
   logic [GAP_W-1:0]   gap_q;
   logic [AMT_W-1:0]   short_q;
   logic               fault_q;
   logic [STOCK_W-1:0] stock_q [3];
   logic [STOCK_W-1:0] stock_d [3];
   logic [STOCK_W:0]   sum     [3];

   logic accept;
   logic paid;
   logic tmo;
   logic gap_end;
   logic to_done;

   assign accept  = req_valid && (state_q == S_IDLE);
   assign paid    = (state_q == S_EJECT) && eject_done;
   assign tmo     = (state_q == S_EJECT) && !eject_done
                    && (tmr_q == TMR_LAST);
   assign gap_end = (state_q == S_GAP) && (gap_q == GAP_LAST);
   assign to_done = ((state_q == S_SELECT) && (sel_d == 3'b000))
                    || tmo;

   // Greedy pick: largest coin that fits the remainder and is in stock
   always_comb begin
      sel_d = 3'b000;
      if (rem_q >= TEN && stock_q[2] != '0)
         sel_d = 3'b100;
      else if (rem_q >= FIVE && stock_q[1] != '0)
         sel_d = 3'b010;
      else if (rem_q >= ONE && stock_q[0] != '0)
         sel_d = 3'b001;
   end

   // Face value of the coin currently being ejected
   always_comb begin
      coin_val = '0;
      unique case (1'b1)
         sel_q[2]: coin_val = TEN;
         sel_q[1]: coin_val = FIVE;
         sel_q[0]: coin_val = ONE;
         default:  coin_val = '0;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:
            if (accept)
               state_d = S_SELECT;
         S_SELECT:
            if (sel_d == 3'b000)
               state_d = S_DONE;
            else
               state_d = S_EJECT;
         S_EJECT:
            if (eject_done)
               state_d = S_GAP;
            else if (tmo)
               state_d = S_DONE;
         S_GAP:
            if (gap_end)
               state_d = S_SELECT;
         S_DONE:
            state_d = S_IDLE;
         default:
            state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from state; eject falls as soon as reset hits
   always_comb begin
      eject     = (state_q == S_EJECT) ? sel_q : 3'b000;
      done      = (state_q == S_DONE);
      busy      = (state_q != S_IDLE);
      req_ready = (state_q == S_IDLE);
      short_amt = short_q;
      fault     = fault_q;
      for (int i = 0; i < 3; i++)
         stock_empty[i] = (stock_q[i] == '0);
   end

   // Remainder, latched coin choice and the eject / gap timers
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         rem_q <= '0;
         sel_q <= 3'b000;
         tmr_q <= '0;
         gap_q <= '0;
      end else begin
         if (accept)
            rem_q <= req_amount;
         else if (paid)
            rem_q <= rem_q - coin_val;
         if (state_q == S_SELECT)
            sel_q <= sel_d;
         if (state_q == S_EJECT)
            tmr_q <= tmr_q + 1'b1;
         else
            tmr_q <= '0;
         if (state_q == S_GAP)
            gap_q <= gap_q + 1'b1;
         else
            gap_q <= '0;
      end
   end

   // Result registers hold from DONE until the next accept
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         short_q <= '0;
         fault_q <= 1'b0;
      end else if (accept) begin
         short_q <= '0;
         fault_q <= 1'b0;
      end else begin
         if (tmo)
            fault_q <= 1'b1;
         if (to_done)
            short_q <= rem_q;
      end
   end

   // Stock update: refill and payout may hit one counter together
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         sum[i] = {1'b0, stock_q[i]};
         if (refill_valid && refill_sel == 2'(i))
            sum[i] = sum[i] + {1'b0, refill_count};
         if (paid && sel_q[i])
            sum[i] = sum[i] - (STOCK_W+1)'(1);
         stock_d[i] = sum[i][STOCK_W] ? '1 : sum[i][STOCK_W-1:0];
      end
   end

   // Stock registers
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         for (int i = 0; i < 3; i++)
            stock_q[i] <= STOCK_RST;
      end else begin
         for (int i = 0; i < 3; i++)
            stock_q[i] <= stock_d[i];
      end
   end

endmodule

// File: tb/tb_change_dispenser_ctrl.sv
// Bench for change_dispenser_ctrl: coin-level model of greedy payout,
// stock and timeout rules, checked every cycle plus directed cases.
module tb_change_dispenser_ctrl;

   logic       clk = 1'b0;
   logic       clear_n;
   logic       req_valid;
   logic       req_ready;
   logic [7:0] req_amount;
   logic [2:0] eject;
   logic       eject_done;
   logic       refill_valid;
   logic [1:0] refill_sel;
   logic [7:0] refill_count;
   logic [2:0] stock_empty;
   logic       busy;
   logic       done;
   logic [7:0] short_amt;
   logic       fault;

   logic mech_done = 1'b0;
   logic man_done;
   logic mech_en;
   int   mech_dly;
   int   wcnt = 0;

   assign eject_done = mech_done | man_done;

   change_dispenser_ctrl dut (
      .clk          (clk),
      .clear_n      (clear_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_amount   (req_amount),
      .eject        (eject),
      .eject_done   (eject_done),
      .refill_valid (refill_valid),
      .refill_sel   (refill_sel),
      .refill_count (refill_count),
      .stock_empty  (stock_empty),
      .busy         (busy),
      .done         (done),
      .short_amt    (short_amt),
      .fault        (fault)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // ---------------- model ----------------
   int   m_stock [3];
   int   m_rem;
   logic m_fault;
   int   hi_cnt;
   logic rel_evt;
   int   m_exp = -1;
   int   coin_log [$];

   function automatic int val(input int d);
      return (d == 2) ? 10 : (d == 1) ? 5 : (d == 0) ? 1 : 0;
   endfunction

   function automatic logic [2:0] onehot(input int d);
      return (d == 2) ? 3'b100 : (d == 1) ? 3'b010 :
             (d == 0) ? 3'b001 : 3'b000;
   endfunction

   function automatic int greedy(input int rem);
      for (int d = 2; d >= 0; d--)
         if (val(d) <= rem && m_stock[d] > 0)
            return d;
      return -1;
   endfunction

   function automatic int sat(input int x);
      return (x > 255) ? 255 : x;
   endfunction

   always @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         for (int i = 0; i < 3; i++)
            m_stock[i] <= 20;
         m_rem   <= 0;
         m_fault <= 1'b0;
         hi_cnt  <= 0;
         rel_evt <= 1'b0;
      end else begin
         rel_evt <= 1'b0;
         for (int i = 0; i < 3; i++)
            m_stock[i] <= sat(m_stock[i]
               + ((refill_valid && int'(refill_sel) == i) ?
                  int'(refill_count) : 0)
               - ((eject != 0 && eject_done && m_exp == i) ? 1 : 0));
         if (req_valid && req_ready) begin
            m_rem   <= int'(req_amount);
            m_fault <= 1'b0;
            hi_cnt  <= 0;
         end else if (eject != 0) begin
            if (eject_done) begin
               m_rem   <= m_rem - val(m_exp);
               hi_cnt  <= 0;
               rel_evt <= 1'b1;
               coin_log.push_back(val(m_exp));
            end else begin
               hi_cnt <= hi_cnt + 1;
               if (hi_cnt == 63)
                  m_fault <= 1'b1;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   logic [2:0] prev_ej   = 3'b000;
   logic       prev_done = 1'b0;

   always @(negedge clk) begin
      if (!clear_n) begin
         prev_ej   = 3'b000;
         prev_done = 1'b0;
      end else begin
         chk("stock_empty", 32'({m_stock[2] == 0, m_stock[1] == 0,
                                 m_stock[0] == 0}), 32'(stock_empty));
         chk("ready_vs_busy", 32'(req_ready), 32'(!busy));
         if (eject != 0 && prev_ej == 0) begin
            m_exp = greedy(m_rem);
            chk("eject_coin", 32'(eject), 32'(onehot(m_exp)));
         end else if (eject != 0) begin
            chk("eject_hold", 32'(eject), 32'(prev_ej));
            chk("eject_time", 32'(hi_cnt < 64), 32'd1);
         end
         if (eject == 0 && prev_ej != 0 && !rel_evt)
            chk("timeout_len", 32'(hi_cnt), 32'd64);
         if (done) begin
            chk("done_pulse", 32'(prev_done), 32'd0);
            chk("short_amt", 32'(short_amt), 32'(m_rem));
            chk("fault", 32'(fault), 32'(m_fault));
            if (!m_fault)
               chk("greedy_exhausted", 32'(greedy(m_rem)), 32'hFFFF_FFFF);
         end
         if (!busy) begin
            chk("idle_short", 32'(short_amt), 32'(m_rem));
            chk("idle_fault", 32'(fault), 32'(m_fault));
            chk("idle_eject", 32'(eject), 32'd0);
         end
         prev_ej   = eject;
         prev_done = done;
      end
   end

   // ---------------- coin mechanism ----------------
   always @(negedge clk) begin
      if (mech_en && eject != 0 && !mech_done) begin
         if (wcnt >= mech_dly) begin
            mech_done = 1'b1;
            wcnt      = 0;
         end else begin
            wcnt = wcnt + 1;
         end
      end else begin
         mech_done = 1'b0;
         wcnt      = 0;
      end
   end

   // ---------------- directed stimulus ----------------
   logic [7:0] d_short;
   logic       d_fault;
   int         ej_hi;

   task automatic wait_done(input string name, input int budget);
      bit got = 1'b0;
      ej_hi = 0;
      for (int c = 0; c < budget; c++) begin
         if (eject == 3'b010)
            ej_hi++;
         if (done) begin
            got     = 1'b1;
            d_short = short_amt;
            d_fault = fault;
            break;
         end
         @(negedge clk);
      end
      if (!got)
         chk({name, "_no_done"}, 32'd0, 32'd1);
      @(negedge clk);
   endtask

   task automatic request(input int amt);
      req_valid  = 1'b1;
      req_amount = 8'(amt);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic pay(input string name, input int amt,
                      input int budget);
      request(amt);
      wait_done(name, budget);
   endtask

   task automatic refill(input int sel, input int cnt);
      refill_valid = 1'b1;
      refill_sel   = 2'(sel);
      refill_count = 8'(cnt);
      @(negedge clk);
      refill_valid = 1'b0;
   endtask

   task automatic wait_eject(input string name);
      bit got = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (eject != 0) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!got)
         chk({name, "_no_eject"}, 32'd0, 32'd1);
   endtask

   initial begin
      int lat;
      clear_n      = 1'b0;
      req_valid    = 1'b0;
      req_amount   = '0;
      refill_valid = 1'b0;
      refill_sel   = '0;
      refill_count = '0;
      man_done     = 1'b0;
      mech_en      = 1'b1;
      mech_dly     = 1;
      repeat (2) @(negedge clk);
      chk("rst_eject", 32'(eject), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_short", 32'(short_amt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_empty", 32'(stock_empty), 32'd0);
      #2 clear_n = 1'b1;
      @(negedge clk);

      // stray eject_done while idle must not move anything
      man_done = 1'b1;
      @(negedge clk);
      man_done = 1'b0;

      // 27 from full stock
      coin_log.delete();
      pay("t1", 27, 200);
      chk("t1_short", 32'(d_short), 32'd0);
      chk("t1_fault", 32'(d_fault), 32'd0);
      chk("t1_ncoins", 32'(coin_log.size()), 32'd5);
      if (coin_log.size() == 5) begin
         chk("t1_c0", 32'(coin_log[0]), 32'd10);
         chk("t1_c1", 32'(coin_log[1]), 32'd10);
         chk("t1_c2", 32'(coin_log[2]), 32'd5);
         chk("t1_c3", 32'(coin_log[3]), 32'd1);
         chk("t1_c4", 32'(coin_log[4]), 32'd1);
      end
      chk("t1_stock10", 32'(m_stock[2]), 32'd18);
      chk("t1_stock5", 32'(m_stock[1]), 32'd19);
      chk("t1_stock1", 32'(m_stock[0]), 32'd18);

      // zero amount: done in the second cycle after accept
      req_valid  = 1'b1;
      req_amount = 8'd0;
      @(posedge clk);
      lat = 0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         req_valid = 1'b0;
         if (done) begin
            lat = c;
            break;
         end
      end
      chk("t2_latency", 32'(lat), 32'd2);
      chk("t2_short", 32'(short_amt), 32'd0);
      @(negedge clk);

      // drain to 10:0 5:0 1:2, then short payout
      pay("drain10", 180, 1500);
      pay("drain5", 95, 1500);
      pay("drain1", 16, 1500);
      pay("t3", 8, 200);
      chk("t3_short", 32'(d_short), 32'd6);
      chk("t3_empty", 32'(stock_empty), 32'b111);

      // eject timeout on a 5 coin
      refill(1, 4);
      mech_en = 1'b0;
      pay("t4", 5, 300);
      chk("t4_fault", 32'(d_fault), 32'd1);
      chk("t4_short", 32'(d_short), 32'd5);
      chk("t4_hi", 32'(ej_hi), 32'd64);
      chk("t4_stock5", 32'(m_stock[1]), 32'd4);
      chk("t4_empty", 32'(stock_empty), 32'b101);

      // refill lands on the same edge a 10 coin is paid
      refill(2, 4);
      request(10);
      wait_eject("t5");
      man_done     = 1'b1;
      refill_valid = 1'b1;
      refill_sel   = 2'd2;
      refill_count = 8'd3;
      @(negedge clk);
      man_done     = 1'b0;
      refill_valid = 1'b0;
      wait_done("t5", 50);
      chk("t5_short", 32'(d_short), 32'd0);
      chk("t5_stock10", 32'(m_stock[2]), 32'd6);
      mech_en = 1'b1;
      pay("t5_d10", 60, 500);
      chk("t5_d10_empty", 32'(stock_empty[2]), 32'd1);
      pay("t5_d5", 20, 500);

      // saturating refill, and selector 3 ignored
      refill(0, 250);
      refill(0, 10);
      chk("t5_sat", 32'(m_stock[0]), 32'd255);
      refill(3, 5);
      chk("t5_sel3", 32'(stock_empty), 32'b110);
      pay("t5_d1", 255, 4000);
      chk("t5_d1_short", 32'(d_short), 32'd0);
      chk("t5_d1_empty", 32'(stock_empty), 32'b111);

      // asynchronous reset mid-eject
      refill(2, 5);
      mech_en = 1'b0;
      request(27);
      wait_eject("t6");
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 clear_n = 1'b0;
      #1;
      chk("t6_async_eject", 32'(eject), 32'd0);
      chk("t6_async_busy", 32'(busy), 32'd0);
      @(negedge clk);
      #2 clear_n = 1'b1;
      @(negedge clk);
      chk("t6_ready", 32'(req_ready), 32'd1);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_empty", 32'(stock_empty), 32'd0);
      mech_en  = 1'b1;
      mech_dly = 0;
      pay("t6_d10", 200, 1500);
      pay("t6_d5", 100, 1500);
      pay("t6_d1", 20, 500);
      chk("t6_short", 32'(d_short), 32'd0);
      chk("t6_drained", 32'(stock_empty), 32'b111);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
